// File: rtl/mem_wb_stage.sv
// MIPS memory stage with the MEM/WB pipeline register: drives the data-memory handshake,
// lane-steers store data, extends load data and stalls upstream while memory is busy.
module mem_wb_stage #(
    parameter int DM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_valid,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_ins,
    input  logic [31:0] M_alu_res,
    input  logic [31:0] M_reg_rs,
    input  logic [31:0] M_reg_rt,
    output logic        M_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        W_valid,
    output logic [31:0] W_PC,
    output logic [31:0] W_ins,
    output logic [31:0] W_alu_res,
    output logic [31:0] W_reg_rs,
    output logic [31:0] W_reg_rt,
    output logic [31:0] W_mem_read,
    output logic        W_exc
);
    localparam int CW = $clog2(DM_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] alu;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] mem_read;
        logic        exc;
    } wreg_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    wreg_t          w_q, w_d;

    logic [5:0]  opc;
    logic [1:0]  off;
    logic        is_load, is_store, is_mem, sz_word, sz_half, sgn, misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    wreg_t       w_pass, w_full, w_abort;

    assign opc = M_ins[31:26];
    assign off = M_alu_res[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_word  = 1'b0;
        sz_half  = 1'b0;
        sgn      = 1'b0;
        case (opc)
            6'h23: begin is_load  = 1'b1; sz_word = 1'b1;             end
            6'h20: begin is_load  = 1'b1; sgn = 1'b1;                 end
            6'h24: begin is_load  = 1'b1;                             end
            6'h21: begin is_load  = 1'b1; sz_half = 1'b1; sgn = 1'b1; end
            6'h25: begin is_load  = 1'b1; sz_half = 1'b1;             end
            6'h2B: begin is_store = 1'b1; sz_word = 1'b1;             end
            6'h28: begin is_store = 1'b1;                             end
            6'h29: begin is_store = 1'b1; sz_half = 1'b1;             end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (sz_word && off != 2'b00) || (sz_half && off[0]);

    // Request side is a pure function of the held M_* inputs, so it stays stable across WAIT.
    assign dm_we   = is_store;
    assign dm_addr = {M_alu_res[31:2], 2'b00};

    always_comb begin
        dm_be    = 4'b0000;
        dm_wdata = 32'h0;
        if (is_store) begin
            if (sz_word) begin
                dm_be    = 4'b1111;
                dm_wdata = M_reg_rt;
            end else if (sz_half) begin
                dm_be    = off[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{M_reg_rt[15:0]}};
            end else begin
                dm_be    = 4'b0001 << off;
                dm_wdata = {4{M_reg_rt[7:0]}};
            end
        end
    end

    assign ld_byte = dm_rdata[{off, 3'b000} +: 8];
    assign ld_half = dm_rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        if (sz_word)      ld_ext = dm_rdata;
        else if (sz_half) ld_ext = {{16{sgn & ld_half[15]}}, ld_half};
        else              ld_ext = {{24{sgn & ld_byte[7]}}, ld_byte};
    end

    always_comb begin
        w_pass   = '{valid: M_valid, pc: M_PC, ins: M_ins, alu: M_alu_res,
                     rs: M_reg_rs, rt: M_reg_rt, mem_read: 32'h0, exc: 1'b0};
        w_full   = w_pass;
        w_full.valid    = 1'b1;
        w_full.mem_read = is_load ? ld_ext : 32'h0;
        // Misaligned or timed-out accesses retire as a flagged nop carrying only the PC.
        w_abort       = '0;
        w_abort.valid = 1'b1;
        w_abort.pc    = M_PC;
        w_abort.exc   = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (!M_valid || !is_mem) begin
                    w_d = w_pass;
                end else if (misaligned) begin
                    w_d = w_abort;
                end else if (dm_ready) begin
                    w_d = w_full;
                end else begin
                    w_d     = '0;
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: begin
                if (dm_ready) begin
                    w_d     = w_full;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DM_TIMEOUT)) begin
                    w_d     = w_abort;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    w_d   = '0;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset gates the handshake outputs so they drop in the same cycle it asserts.
    always_comb begin
        dm_req  = 1'b0;
        M_stall = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    dm_req  = M_valid && is_mem && !misaligned;
                    M_stall = dm_req && !dm_ready;
                end
                WAIT: begin
                    dm_req  = 1'b1;
                    M_stall = !dm_ready && (cnt_q != CW'(DM_TIMEOUT));
                end
                default: ;
            endcase
        end
    end

    assign W_valid    = w_q.valid;
    assign W_PC       = w_q.pc;
    assign W_ins      = w_q.ins;
    assign W_alu_res  = w_q.alu;
    assign W_reg_rs   = w_q.rs;
    assign W_reg_rt   = w_q.rt;
    assign W_mem_read = w_q.mem_read;
    assign W_exc      = w_q.exc;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected W records are queued at issue and
// compared whenever W_valid rises; handshake outputs are checked per cycle.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        M_valid;
    logic [31:0] M_PC, M_ins, M_alu_res, M_reg_rs, M_reg_rt;
    logic        M_stall, dm_req, dm_we, dm_ready;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        W_valid, W_exc;
    logic [31:0] W_PC, W_ins, W_alu_res, W_reg_rs, W_reg_rt, W_mem_read;

    typedef struct {
        logic [31:0] pc, ins, alu, rs, rt, mem_read;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] pc_ctr = 32'h0000_0400;

    mem_wb_stage #(.DM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .M_valid(M_valid), .M_PC(M_PC), .M_ins(M_ins), .M_alu_res(M_alu_res),
        .M_reg_rs(M_reg_rs), .M_reg_rt(M_reg_rt), .M_stall(M_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .W_valid(W_valid), .W_PC(W_PC), .W_ins(W_ins), .W_alu_res(W_alu_res),
        .W_reg_rs(W_reg_rs), .W_reg_rt(W_reg_rt), .W_mem_read(W_mem_read), .W_exc(W_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 5'd4, 5'd5, 16'h0010};
    endfunction

    // Scoreboard: every W_valid beat consumes one queued expectation.
    initial forever begin
        @(posedge clk); #1;
        if (!reset && W_valid) begin
            if (sb_q.size() == 0) begin
                check("w_unexpected", 32'(W_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("w_pc",   W_PC,       e.pc);
                check("w_ins",  W_ins,      e.ins);
                check("w_exc",  32'(W_exc), 32'(e.exc));
                check("w_mrd",  W_mem_read, e.mem_read);
                if (!e.exc) begin
                    check("w_alu", W_alu_res, e.alu);
                    check("w_rs",  W_reg_rs,  e.rs);
                    check("w_rt",  W_reg_rt,  e.rt);
                end
            end
        end
    end

    // Called at posedge+1; holds M_* while stalled, dm_ready rises after 'lat' cycles.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input int lat, input logic exp_req,
                          input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_mrd, input logic exp_exc, input int exp_stalls);
        exp_t e;
        int   stalls = 0;
        logic st;
        logic done = 1'b0;
        M_valid = 1'b1; M_PC = pc_ctr; M_ins = ins; M_alu_res = addr;
        M_reg_rs = pc_ctr ^ 32'hA5A5_0000; M_reg_rt = rt; dm_rdata = rdata;
        e.pc = pc_ctr; e.ins = exp_exc ? 32'h0 : ins; e.alu = addr; e.rs = M_reg_rs;
        e.rt = rt; e.mem_read = exp_mrd; e.exc = exp_exc;
        sb_q.push_back(e);
        pc_ctr += 32'd4;
        for (int c = 0; c < 20 && !done; c++) begin
            dm_ready = (c >= lat);
            #4;
            check("dm_req", 32'(dm_req), 32'(exp_req));
            if (exp_req) begin
                check("dm_addr", dm_addr, {addr[31:2], 2'b00});
                if (c == 0) begin
                    check("dm_we", 32'(dm_we), 32'(exp_we));
                    check("dm_be", 32'(dm_be), 32'(exp_be));
                    if (exp_we) check("dm_wdata", dm_wdata, exp_wd);
                end
            end
            st = M_stall;
            if (st) stalls++;
            @(posedge clk); #1;
            if (st) check("bubble", 32'(W_valid), 32'h0);
            else done = 1'b1;
        end
        if (!done) check("op_timeout", 32'h0, 32'h1);
        check("stalls", 32'(stalls), 32'(exp_stalls));
        M_valid = 1'b0; dm_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; M_valid = 1'b0; M_PC = 32'h0; M_ins = 32'h0; M_alu_res = 32'h0;
        M_reg_rs = 32'h0; M_reg_rt = 32'h0; dm_ready = 1'b0; dm_rdata = 32'h0;
        #12;
        check("rst_wvalid", 32'(W_valid), 32'h0);
        check("rst_wpc",    W_PC,         32'h0);
        check("rst_walu",   W_alu_res,    32'h0);
        check("rst_req",    32'(dm_req),  32'h0);
        check("rst_stall",  32'(M_stall), 32'h0);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;

        // addu passes straight through
        run_op(32'h0022_1821, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        // lb with two wait cycles
        run_op(mk(6'h20), 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 2, 1, 0, 4'h0, 32'h0, 32'hFFFF_FF80, 0, 2);
        // sh upper half, ready at once
        run_op(mk(6'h29), 32'h0000_2002, 32'hAAAA_5678, 32'h0, 0, 1, 1, 4'hC, 32'h5678_5678, 32'h0, 0, 0);
        // misaligned lw, then an ordinary op follows unstalled
        run_op(mk(6'h23), 32'h0000_0006, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        run_op(32'h0022_1821, 32'h0000_0077, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        // lane/extension coverage
        run_op(mk(6'h21), 32'h0000_3002, 32'h0, 32'h8001_1234, 1, 1, 0, 4'h0, 32'h0, 32'hFFFF_8001, 0, 1);
        run_op(mk(6'h25), 32'h0000_3002, 32'h0, 32'h8001_1234, 0, 1, 0, 4'h0, 32'h0, 32'h0000_8001, 0, 0);
        run_op(mk(6'h23), 32'h0000_3000, 32'h0, 32'h1234_5678, 0, 1, 0, 4'h0, 32'h0, 32'h1234_5678, 0, 0);
        run_op(mk(6'h28), 32'h0000_0013, 32'h1234_565A, 32'h0, 0, 1, 1, 4'h8, 32'h5A5A_5A5A, 32'h0, 0, 0);
        run_op(mk(6'h2B), 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 3, 1, 1, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 3);
        run_op(mk(6'h29), 32'h0000_2001, 32'h0000_1111, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        // timeout abort after four stall cycles
        run_op(mk(6'h23), 32'h0000_0040, 32'h0, 32'hFFFF_FFFF, 1000, 1, 0, 4'h0, 32'h0, 32'h0, 1, 4);
        dm_ready = 1'b1;
        #4;
        check("late_rdy_req",   32'(dm_req),  32'h0);
        check("late_rdy_stall", 32'(M_stall), 32'h0);
        @(posedge clk); #1;
        check("late_rdy_w", 32'(W_valid), 32'h0);
        dm_ready = 1'b0;

        // reset asserted while waiting on memory
        M_valid = 1'b1; M_PC = 32'h0000_0900; M_ins = mk(6'h23); M_alu_res = 32'h0000_0050;
        #4;
        check("pre_rst_stall", 32'(M_stall), 32'h1);
        @(posedge clk); #1;
        check("wait_req", 32'(dm_req), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midrst_req",   32'(dm_req),  32'h0);
        check("midrst_stall", 32'(M_stall), 32'h0);
        check("midrst_wv",    32'(W_valid), 32'h0);
        check("midrst_wpc",   W_PC,         32'h0);
        M_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
        run_op(mk(6'h24), 32'h0000_1001, 32'h0, 32'h0000_AB00, 0, 1, 0, 4'h0, 32'h0, 32'h0000_00AB, 0, 0);

        @(posedge clk); #2;
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
